// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: the instruction-memory request/response port and the decode handshake.
// The master modport is the fetch_queue side. The slave modport is the memory/decode side.
interface fetch_queue_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        dec_ready;
  logic        dec_valid;
  logic [15:0] instr;
  logic [15:0] PC;
  logic [15:0] PCPlus1;

  modport master (
    output imem_req, imem_addr, dec_valid, instr, PC, PCPlus1,
    input  imem_gnt, imem_rvalid, imem_rdata, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, instr, PC, PCPlus1,
    output imem_gnt, imem_rvalid, imem_rdata, dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: issues in-order imem reads and buffers {pc, inst} in a DEPTH-entry FIFO for decode.
// Define FETCH_BYPASS_EN to pass a response straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] newPC,
  input  logic        jorb,
  input  logic        halt,
  fetch_queue_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [15:0]   r_fetchPc;
  logic [15:0]   r_respPc;
  logic [15:0]   r_lastPc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_dropCnt;
  logic          r_halted;
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [15:0]   r_memPc   [DEPTH];
  logic [15:0]   r_memInst [DEPTH];

  logic          w_empty;
  logic          w_credit;
  logic          w_req;
  logic          w_grant;
  logic          w_rvalid;
  logic          w_dropping;
  logic          w_bypass;
  logic          w_decValid;
  logic          w_pop;
  logic          w_accept;
  logic          w_push;
  logic [CW-1:0] w_outstandingNext;
  logic [15:0]   w_outPc;
  logic [15:0]   w_outInst;

  // Entries plus in-flight requests never exceed DEPTH, so a push can never find the FIFO full.
  assign w_empty    = (r_count == '0);
  assign w_credit   = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_W;
  assign w_req      = rst && !r_halted && !halt && !jorb && w_credit;
  assign w_grant    = w_req && bus.imem_gnt;
  assign w_rvalid   = bus.imem_rvalid && (r_outstanding != '0);
  assign w_dropping = (r_dropCnt != '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty && w_rvalid && !w_dropping && !jorb;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_decValid = !w_empty || w_bypass;
  assign w_pop      = !w_empty && bus.dec_ready;
  assign w_accept   = w_rvalid && !w_dropping && !jorb;
  assign w_push     = w_accept && !(w_bypass && bus.dec_ready);
  assign w_outstandingNext = r_outstanding + CW'(w_grant) - CW'(w_rvalid);

  always_comb begin
    w_outPc   = r_lastPc;
    w_outInst = NOP_INST;
    if (!w_empty) begin
      w_outPc   = r_memPc[r_rdPtr];
      w_outInst = r_memInst[r_rdPtr];
    end else if (w_bypass) begin
      w_outPc   = r_respPc;
      w_outInst = bus.imem_rdata;
    end
  end

  // A redirect flushes the FIFO and turns every older in-flight response into a drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetchPc     <= RESET_PC;
      r_respPc      <= RESET_PC;
      r_lastPc      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_dropCnt     <= '0;
      r_halted      <= 1'b0;
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
    end else begin
      r_halted      <= r_halted || halt;
      r_outstanding <= w_outstandingNext;
      if (w_decValid) begin
        r_lastPc <= w_outPc;
      end
      if (jorb) begin
        r_fetchPc <= newPC;
        r_respPc  <= newPC;
        r_count   <= '0;
        r_wrPtr   <= '0;
        r_rdPtr   <= '0;
        r_dropCnt <= w_outstandingNext;
      end else begin
        if (w_grant) begin
          r_fetchPc <= r_fetchPc + 16'd1;
        end
        if (w_rvalid && w_dropping) begin
          r_dropCnt <= r_dropCnt - CW'(1);
        end
        if (w_accept) begin
          r_respPc <= r_respPc + 16'd1;
        end
        if (w_push) begin
          r_wrPtr <= r_wrPtr + AW'(1);
        end
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memPc[r_wrPtr]   <= r_respPc;
      r_memInst[r_wrPtr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetchPc;
  assign bus.dec_valid = w_decValid;
  assign bus.instr     = w_outInst;
  assign bus.PC        = w_outPc;
  assign bus.PCPlus1   = w_outPc + 16'd1;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a 2-cycle-latency memory model plus an in-order scoreboard of {pc, inst}.
module tb_fetch_queue;
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } entry_t;

  logic        clk;
  logic        rst;
  logic [15:0] newPC;
  logic        jorb;
  logic        halt;
  logic        tbGnt;
  logic        tbReady;
  logic        memAuto;
  logic        manRv;
  logic [15:0] manRd;
  logic        autoRv;
  logic [15:0] autoRd;
  int          errors;
  int          checks;
  entry_t      expQ[$];

  fetch_queue_if bus();

  assign bus.imem_gnt    = tbGnt;
  assign bus.imem_rvalid = memAuto ? autoRv : manRv;
  assign bus.imem_rdata  = memAuto ? autoRd : manRd;
  assign bus.dec_ready   = tbReady;

  fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000), .NOP_INST(16'h1000)) dut (
    .clk(clk), .rst(rst), .newPC(newPC), .jorb(jorb), .halt(halt), .bus(bus)
  );

  function automatic logic [15:0] memData(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: data returns two cycles after the granting cycle, in order.
  initial begin
    logic        s1v;
    logic [15:0] s1d;
    logic        g;
    logic [15:0] ga;
    s1v = 1'b0; s1d = '0; autoRv = 1'b0; autoRd = '0;
    forever begin
      @(negedge clk);
      g  = memAuto && rst && bus.imem_req && bus.imem_gnt;
      ga = bus.imem_addr;
      @(posedge clk);
      #1;
      if (!memAuto || !rst) begin
        autoRv = 1'b0;
        s1v    = 1'b0;
      end else begin
        autoRv = s1v;
        autoRd = s1d;
        s1v    = g;
        s1d    = memData(ga);
      end
    end
  end

  // Scoreboard: push on each grant, flush on redirect or reset, pop and compare on each delivery.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        expQ.delete();
      end else begin
        if (jorb) begin
          expQ.delete();
        end else if (bus.dec_valid && bus.dec_ready) begin
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_unexpected: got pc=%h instr=%h, required no delivery", bus.PC, bus.instr);
          end else begin
            e = expQ.pop_front();
            if ({bus.instr, bus.PC, bus.PCPlus1} !== {e.inst, e.pc, e.pc + 16'd1}) begin
              errors++;
              $display("[TB] FAIL sb_order: got instr=%h pc=%h pc1=%h, required instr=%h pc=%h pc1=%h",
                       bus.instr, bus.PC, bus.PCPlus1, e.inst, e.pc, e.pc + 16'd1);
            end
          end
        end
        if (bus.imem_req && bus.imem_gnt) begin
          expQ.push_back({bus.imem_addr, memData(bus.imem_addr)});
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b, required 0", bus.imem_req); end
    checks++;
    if (bus.dec_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, required 0", bus.dec_valid); end
    checks++;
    if (bus.instr !== 16'h1000) begin errors++; $display("[TB] FAIL reset_instr: got %h, required 1000", bus.instr); end
    checks++;
    if (bus.PC !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc: got %h, required 0000", bus.PC); end
    checks++;
    if (bus.PCPlus1 !== 16'h0001) begin errors++; $display("[TB] FAIL reset_pc1: got %h, required 0001", bus.PCPlus1); end
  endtask

  task automatic test_stream();
    logic [15:0] addrs[$];
    int grantCyc;
    int firstValid;
    int deliv;
    grantCyc = -1; firstValid = -1; deliv = 0;
    @(posedge clk); #1;
    rst = 1'b1; tbGnt = 1'b1; tbReady = 1'b1; memAuto = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_gnt) begin
        addrs.push_back(bus.imem_addr);
        if (grantCyc < 0) grantCyc = c;
      end
      if (bus.dec_valid && firstValid < 0) firstValid = c;
      if (bus.dec_valid && bus.dec_ready) deliv++;
    end
    @(posedge clk); #1;
    tbGnt = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.dec_valid && bus.dec_ready) deliv++;
    end
    checks++;
    if (addrs.size() != 20) begin errors++; $display("[TB] FAIL stream_grants: got %0d, required 20", addrs.size()); end
    for (int i = 0; i < addrs.size(); i++) begin
      checks++;
      if (addrs[i] !== 16'(i)) begin errors++; $display("[TB] FAIL stream_addr%0d: got %h, required %h", i, addrs[i], 16'(i)); end
    end
    checks++;
    if (grantCyc != 1) begin errors++; $display("[TB] FAIL stream_first_grant: got cycle %0d, required 1", grantCyc); end
    checks++;
    if (firstValid != 4) begin errors++; $display("[TB] FAIL stream_latency: got cycle %0d, required 4", firstValid); end
    checks++;
    if (deliv != 20) begin errors++; $display("[TB] FAIL stream_delivered: got %0d, required 20", deliv); end
  endtask

  task automatic test_backpressure();
    int grants;
    int deliv;
    grants = 0; deliv = 0;
    @(posedge clk); #1;
    tbReady = 1'b0; tbGnt = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_gnt) grants++;
    end
    checks++;
    if (grants != 4) begin errors++; $display("[TB] FAIL bp_grants: got %0d, required 4", grants); end
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_off: got %b, required 0", bus.imem_req); end
    checks++;
    if (bus.dec_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %b, required 1", bus.dec_valid); end
    @(posedge clk); #1;
    tbGnt = 1'b0; tbReady = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.dec_valid && bus.dec_ready) deliv++;
    end
    checks++;
    if (deliv != 4) begin errors++; $display("[TB] FAIL bp_delivered: got %0d, required 4", deliv); end
    checks++;
    if (bus.dec_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got %b, required 0", bus.dec_valid); end
  endtask

  task automatic test_redirect();
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    tbReady = 1'b0; tbGnt = 1'b0; jorb = 1'b1; newPC = 16'h000E;
    @(posedge clk); #1;
    jorb = 1'b0; tbGnt = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    tbGnt = 1'b0; jorb = 1'b1; newPC = 16'h0100;
    @(negedge clk);
    checks++;
    if (bus.dec_valid !== 1'b1) begin errors++; $display("[TB] FAIL rd_queued: got %b, required 1", bus.dec_valid); end
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rd_req_jorb: got %b, required 0", bus.imem_req); end
    @(posedge clk); #1;
    jorb = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dec_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_flushed: got %b, required 0", bus.dec_valid); end
    checks++;
    if (bus.instr !== 16'h1000) begin errors++; $display("[TB] FAIL rd_nop: got %h, required 1000", bus.instr); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.dec_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_dropped: got %b, required 0", bus.dec_valid); end
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'h0100}) begin
      errors++; $display("[TB] FAIL rd_next_req: got req=%b addr=%h, required req=1 addr=0100", bus.imem_req, bus.imem_addr);
    end
    @(posedge clk); #1;
    tbGnt = 1'b1; tbReady = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.dec_valid) begin
        seen = 1'b1;
        checks++;
        if (bus.PC !== 16'h0100) begin errors++; $display("[TB] FAIL rd_first_pc: got %h, required 0100", bus.PC); end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL rd_timeout: got no dec_valid in 10 cycles, required delivery");
    end
    @(posedge clk); #1;
    tbGnt = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    @(posedge clk); #1;
    tbGnt = 1'b0; tbReady = 1'b1; jorb = 1'b1; newPC = 16'hFFFF;
    @(posedge clk); #1;
    jorb = 1'b0; tbGnt = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'hFFFF}) begin
      errors++; $display("[TB] FAIL wrap_addr0: got req=%b addr=%h, required req=1 addr=ffff", bus.imem_req, bus.imem_addr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("[TB] FAIL wrap_addr1: got req=%b addr=%h, required req=1 addr=0000", bus.imem_req, bus.imem_addr);
    end
    @(posedge clk); #1;
    tbGnt = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.dec_valid && n == 0) begin
        checks++;
        if ({bus.PC, bus.PCPlus1} !== {16'hFFFF, 16'h0000}) begin
          errors++; $display("[TB] FAIL wrap_pc1: got pc=%h pc1=%h, required pc=ffff pc1=0000", bus.PC, bus.PCPlus1);
        end
        n = 1;
      end else if (bus.dec_valid && n == 1) begin
        checks++;
        if ({bus.PC, bus.PCPlus1} !== {16'h0000, 16'h0001}) begin
          errors++; $display("[TB] FAIL wrap_pc2: got pc=%h pc1=%h, required pc=0000 pc1=0001", bus.PC, bus.PCPlus1);
        end
        n = 2;
      end
    end
    checks++;
    if (n != 2) begin errors++; $display("[TB] FAIL wrap_count: got %0d, required 2", n); end
  endtask

  task automatic test_halt();
    int deliv;
    logic reqSeen;
    deliv = 0; reqSeen = 1'b0;
    @(posedge clk); #1;
    tbReady = 1'b0; tbGnt = 1'b0; jorb = 1'b1; newPC = 16'h0020;
    @(posedge clk); #1;
    jorb = 1'b0; tbGnt = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    tbGnt = 1'b0;
    @(posedge clk); #1;
    halt = 1'b1; tbGnt = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_req: got %b, required 0", bus.imem_req); end
    checks++;
    if (bus.dec_valid !== 1'b1) begin errors++; $display("[TB] FAIL halt_queued: got %b, required 1", bus.dec_valid); end
    @(posedge clk); #1;
    halt = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_sticky: got %b, required 0", bus.imem_req); end
    @(posedge clk); #1;
    tbReady = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.imem_req) reqSeen = 1'b1;
      if (bus.dec_valid && bus.dec_ready) deliv++;
    end
    checks++;
    if (deliv != 3) begin errors++; $display("[TB] FAIL halt_delivered: got %0d, required 3", deliv); end
    checks++;
    if (reqSeen !== 1'b0) begin errors++; $display("[TB] FAIL halt_no_req: got %b, required 0", reqSeen); end
    checks++;
    if ({bus.dec_valid, bus.instr} !== {1'b0, 16'h1000}) begin
      errors++; $display("[TB] FAIL halt_empty: got valid=%b instr=%h, required valid=0 instr=1000", bus.dec_valid, bus.instr);
    end
    checks++;
    if ({bus.PC, bus.PCPlus1} !== {16'h0022, 16'h0023}) begin
      errors++; $display("[TB] FAIL halt_pc_hold: got pc=%h pc1=%h, required pc=0022 pc1=0023", bus.PC, bus.PCPlus1);
    end
    @(posedge clk); #1;
    tbGnt = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; tbGnt = 1'b1; tbReady = 1'b1; memAuto = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.imem_req, bus.dec_valid} !== 2'b00) begin
      errors++; $display("[TB] FAIL mid_req_valid: got req=%b valid=%b, required 0 0", bus.imem_req, bus.dec_valid);
    end
    checks++;
    if ({bus.instr, bus.PC, bus.PCPlus1} !== {16'h1000, 16'h0000, 16'h0001}) begin
      errors++; $display("[TB] FAIL mid_outputs: got instr=%h pc=%h pc1=%h, required 1000 0000 0001", bus.instr, bus.PC, bus.PCPlus1);
    end
    repeat (2) @(posedge clk);
    #1;
    memAuto = 1'b0; manRv = 1'b0; tbGnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("[TB] FAIL mid_restart: got req=%b addr=%h, required req=1 addr=0000", bus.imem_req, bus.imem_addr);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      manRv = 1'b1; manRd = 16'hBEEF;
      @(negedge clk);
    end
    @(posedge clk); #1;
    manRv = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.dec_valid, bus.instr} !== {1'b0, 16'h1000}) begin
      errors++; $display("[TB] FAIL mid_late_rvalid: got valid=%b instr=%h, required valid=0 instr=1000", bus.dec_valid, bus.instr);
    end
    @(posedge clk); #1;
    memAuto = 1'b1; tbGnt = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.dec_valid) begin
        seen = 1'b1;
        checks++;
        if (bus.PC !== 16'h0000) begin errors++; $display("[TB] FAIL mid_first_pc: got %h, required 0000", bus.PC); end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL mid_timeout: got no dec_valid in 10 cycles, required delivery");
    end
    @(posedge clk); #1;
    tbGnt = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish by 400000, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0; newPC = '0; jorb = 1'b0; halt = 1'b0;
    tbGnt = 1'b0; tbReady = 1'b0; memAuto = 1'b0; manRv = 1'b0; manRd = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Prefetching instruction-fetch stage that sits directly upstream of decode.
- Issues in-order 16-bit instruction reads to instruction memory, tolerating variable latency, and buffers the returned words with their PCs in a DEPTH-entry FIFO.
- Presents the head entry to the fetch/decode pipeline register under a valid/ready handshake.
- Handles jump/branch redirects from execute and the sticky halt from writeback; discards stale in-flight responses after a redirect.

Parameters:
- DEPTH, 4: FIFO entries; also the limit on (entries + outstanding requests); power of two, at least 2.
- RESET_PC, 16'h0000: first fetch address after reset.
- NOP_INST, 16'h1000: word driven on instr when the FIFO is empty.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- newPC  in  16  redirect target from execute.
- jorb  in  1  redirect strobe; newPC is valid while this is high.
- halt  in  1  halt indication from writeback; sticky once seen.
- imem_req  out  1  read request.
- imem_addr  out  16  read address (current fetch PC).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; responses return in order.
- imem_rdata  in  16  read data.
- dec_ready  in  1  decode can accept an instruction this cycle.
- dec_valid  out  1  instr, PC and PCPlus1 are valid.
- instr  out  16  head instruction, or NOP_INST when empty.
- PC  out  16  PC of the head instruction.
- PCPlus1  out  16  PC+1, modulo 2^16.

Behaviour:
- State registers:
  - fetch_pc (16); resp_pc (16).
  - count: 0..DEPTH. outstanding: 0..DEPTH. drop_cnt: 0..DEPTH.
  - halted (1); FIFO storage of {pc, inst}.
- Reset (rst=0, asynchronous): fetch_pc = resp_pc = RESET_PC; count, outstanding, drop_cnt and halted = 0.
- Reset values of outputs: imem_req=0 and dec_valid=0 during reset; instr=NOP_INST, PC=0, PCPlus1=1. Reset mid-operation abandons all in-flight requests.
- Request issue:
  - imem_req = !halted && !halt && !jorb && (count + outstanding < DEPTH).
  - imem_addr = fetch_pc.
  - A grant is imem_req && imem_gnt. On a grant: fetch_pc += 1 (16'hFFFF wraps to 16'h0000) and outstanding += 1.
  - imem_req is held until granted; it is combinational with the conditions above.
- Response handling (imem_rvalid=1):
  - outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the data is discarded.
  - Otherwise: push {resp_pc, imem_rdata} and resp_pc += 1 (wraps).
  - imem_rvalid while outstanding==0 is a protocol violation and is ignored; no state changes.
- Output side:
  - dec_valid = (count != 0).
  - instr, PC = head entry. PCPlus1 = PC + 1 (16-bit wrap).
  - Pop when dec_valid && dec_ready.
  - When empty: instr = NOP_INST, PC holds its last value, and PCPlus1 is derived from PC.
- Latency: imem_rvalid in cycle N gives dec_valid in cycle N+1 (no bypass).
- FIFO boundaries:
  - Push and pop in the same cycle leave count unchanged and are legal at full or non-empty.
  - Pointers wrap modulo DEPTH.
  - The credit rule guarantees no overflow; a push at full cannot occur.
- Redirect (jorb=1), which has priority over everything else:
  - FIFO cleared (count=0; pointers reset); any pop in the same cycle is ignored.
  - fetch_pc and resp_pc load newPC.
  - No request is issued that cycle.
  - A response in the same cycle is discarded.
  - outstanding_next = outstanding - rvalid, and drop_cnt_next = outstanding_next, so every older in-flight response is dropped.
  - Back-to-back jorb pulses: the last one wins, and drop_cnt tracks outstanding.
- Halt:
  - halted is set on any cycle with halt=1 and is cleared only by reset.
  - While halted: no new requests. Outstanding responses are still accepted or dropped normally. The FIFO continues to drain to decode.
  - jorb while halted still flushes the FIFO and loads fetch_pc, but issues nothing.

Optional Feature:
FETCH_BYPASS_EN
- Defined, when count==0, imem_rvalid=1 and drop_cnt==0:
  - dec_valid=1 in the same cycle, with instr=imem_rdata, PC=resp_pc and PCPlus1=resp_pc+1.
  - If dec_ready=1 the word is consumed and not written to the FIFO; otherwise it is written normally.
  - Zero-latency path; jorb in the same cycle suppresses the bypass.
- Undefined: one-cycle latency as specified above.

Test Plan:
- Reset release; memory grants every cycle with 2-cycle data latency; dec_ready=1 -> requests 0x0000, 0x0001, ...; dec_valid first asserted in cycle 4; instr/PC pairs in order; PCPlus1 = PC+1.
- dec_ready=0 with DEPTH=4 -> at most 4 grants; imem_req=0 once count+outstanding=4; raising dec_ready releases entries in order; no loss or duplication.
- 2 requests outstanding (0x0010, 0x0011), then jorb with newPC=0x0100 -> FIFO empties; the next two rvalids are dropped; the next request is 0x0100; first instr delivered has PC=0x0100.
- fetch_pc=0xFFFF -> requests 0xFFFF then 0x0000; for the 0xFFFF entry PCPlus1=0x0000.
- halt pulse with 1 outstanding and 2 queued -> no further imem_req; 3 instructions delivered, then dec_valid=0 and instr=0x1000.
- rst=0 asserted mid-stream between clock edges -> outputs take reset values immediately; after release, fetch restarts at RESET_PC and late rvalids are ignored.
